prog_loader: RTL and testbench

Parametrised program loader and run controller for the single-cycle processor. It accepts instruction words from a host over a valid/ready stream and writes them into instruction memory at consecutive addresses. It then raises `working` for a programmed number of cycles and optionally records the processor's per-cycle `valE` into a trace buffer for readback. It replaces hand-sequenced `addr`/`wEn`/`wDat`/`working` driving in benches and board bring-up.

---
 rtl/prog_loader_if.sv | 33 +++
 rtl/prog_loader.sv | 205 ++++++++++++++++++++
 tb/tb_prog_loader.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// prog_loader_if
//   Groups the host word stream and the instruction-memory write port of prog_loader.
//   slave  : loader side - takes s_valid/s_data, drives s_ready, addr, wEn, wDat
//   master : host side   - drives s_valid/s_data, observes s_ready and the write port
interface prog_loader_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9
) ();
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [ADDR_W-1:0] addr;
    logic              wEn;
    logic [DATA_W-1:0] wDat;

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        output addr,
        output wEn,
        output wDat
    );

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        input  addr,
        input  wEn,
        input  wDat
    );
endinterface

// File: rtl/prog_loader.sv
// prog_loader
//   Loads a program from a valid/ready host stream into instruction memory at consecutive
//   addresses, then holds `working` for a programmed number of cycles. Optionally records
//   the processor's valE on every working cycle into a small trace buffer.
//
//   Ports:
//     clock, reset        rising-edge clock, synchronous active-high reset
//     start               begins a load/run sequence (accepted in IDLE or DONE only)
//     prog_len            words to load, clamped to 2^ADDR_W, sampled on accepted start
//     run_cycles          cycles to hold working, sampled on accepted start
//     bus (slave)         s_valid/s_ready/s_data stream in; addr/wEn/wDat memory write out
//     working             processor run enable
//     busy, done          state is LOAD/RUN, state is DONE
//     valE                processor ALU result, captured while working
//     trace_count         number of valid trace entries (saturates at TRACE_DEPTH)
//     trace_raddr/rdata   trace read port, data registered one cycle after the address
//
//   Build option: define PROG_LOADER_TRACE_EN to build the trace buffer. Without it,
//   trace_count and trace_rdata are tied to 0 and valE/trace_raddr are ignored.
module prog_loader #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 9,
    parameter int unsigned CYC_W       = 16,
    parameter int unsigned TRACE_DEPTH = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           start,
    input  logic [ADDR_W:0]                prog_len,
    input  logic [CYC_W-1:0]               run_cycles,
    prog_loader_if.slave                   bus,
    output logic                           working,
    output logic                           busy,
    output logic                           done,
    input  logic [DATA_W-1:0]              valE,
    output logic [$clog2(TRACE_DEPTH):0]   trace_count,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_raddr,
    output logic [DATA_W-1:0]              trace_rdata
);
    localparam int unsigned     TW      = $clog2(TRACE_DEPTH);
    localparam logic [ADDR_W:0] MaxLen  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] WcntOne = (ADDR_W+1)'(1);
    localparam logic [CYC_W-1:0] CycOne = CYC_W'(1);

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d, len_clamped;
    logic [ADDR_W:0]   wcnt_q, wcnt_d;
    logic [CYC_W-1:0]  lim_q, lim_d;
    logic [CYC_W-1:0]  ccnt_q, ccnt_d;
    logic              s_ready_q, s_ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wen_q, wen_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic              working_q, working_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              trace_clr;

    always_comb begin
        len_clamped = (prog_len > MaxLen) ? MaxLen : prog_len;
        state_d     = state_q;
        len_d       = len_q;
        wcnt_d      = wcnt_q;
        lim_d       = lim_q;
        ccnt_d      = ccnt_q;
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        wen_d       = 1'b0;
        working_d   = 1'b0;
        trace_clr   = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    len_d     = len_clamped;
                    lim_d     = run_cycles;
                    wcnt_d    = '0;
                    ccnt_d    = '0;
                    trace_clr = 1'b1;
                    if (len_clamped == '0) begin
                        // Nothing to load: the first run cycle is the one right after start.
                        state_d = StRun;
                        if (run_cycles != '0) begin
                            working_d = 1'b1;
                            ccnt_d    = CycOne;
                        end
                    end else begin
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                if (bus.s_valid && s_ready_q) begin
                    wen_d  = 1'b1;
                    addr_d = wcnt_q[ADDR_W-1:0];
                    wdat_d = bus.s_data;
                    wcnt_d = wcnt_q + WcntOne;
                    // RUN is entered with working low, so the last write never overlaps it.
                    if (wcnt_d == len_q) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (ccnt_q < lim_q) begin
                    working_d = 1'b1;
                    ccnt_d    = ccnt_q + CycOne;
                end else begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        s_ready_d = (state_d == StLoad);
        busy_d    = (state_d == StLoad) || (state_d == StRun);
        done_d    = (state_d == StDone);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= StIdle;
            len_q     <= '0;
            wcnt_q    <= '0;
            lim_q     <= '0;
            ccnt_q    <= '0;
            s_ready_q <= 1'b0;
            addr_q    <= '0;
            wen_q     <= 1'b0;
            wdat_q    <= '0;
            working_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wcnt_q    <= wcnt_d;
            lim_q     <= lim_d;
            ccnt_q    <= ccnt_d;
            s_ready_q <= s_ready_d;
            addr_q    <= addr_d;
            wen_q     <= wen_d;
            wdat_q    <= wdat_d;
            working_q <= working_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.addr    = addr_q;
    assign bus.wEn     = wen_q;
    assign bus.wDat    = wdat_q;
    assign working     = working_q;
    assign busy        = busy_q;
    assign done        = done_q;

`ifdef PROG_LOADER_TRACE_EN
    localparam logic [TW:0] TraceFull = (TW+1)'(TRACE_DEPTH);
    localparam logic [TW:0] TcntOne   = (TW+1)'(1);

    logic [DATA_W-1:0] trace_mem [TRACE_DEPTH];
    logic [TW:0]       tcnt_q, tcnt_d;
    logic [DATA_W-1:0] rdata_q;
    logic              capture;

    // Capture saturates rather than wrapping, so entry k is always the k-th run cycle.
    always_comb begin
        capture = working_q && (tcnt_q < TraceFull);
        tcnt_d  = tcnt_q;
        if (trace_clr) begin
            tcnt_d = '0;
        end else if (capture) begin
            tcnt_d = tcnt_q + TcntOne;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tcnt_q  <= '0;
            rdata_q <= '0;
        end else begin
            tcnt_q  <= tcnt_d;
            rdata_q <= trace_mem[trace_raddr];
        end
    end

    // No reset on the storage so it can map onto a RAM.
    always_ff @(posedge clock) begin
        if (capture) begin
            trace_mem[tcnt_q[TW-1:0]] <= valE;
        end
    end

    assign trace_count = tcnt_q;
    assign trace_rdata = rdata_q;
`else
    logic unused_trace;
    assign unused_trace = ^{valE, trace_raddr, trace_clr};
    assign trace_count  = '0;
    assign trace_rdata  = '0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
module tb_prog_loader;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned ADDR_W      = 4;
    localparam int unsigned CYC_W       = 8;
    localparam int unsigned TRACE_DEPTH = 4;
    localparam int unsigned TW          = $clog2(TRACE_DEPTH);
    localparam int          MaxLen      = 1 << ADDR_W;
`ifdef PROG_LOADER_TRACE_EN
    localparam bit TraceOn = 1'b1;
`else
    localparam bit TraceOn = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   prog_len;
    logic [CYC_W-1:0]  run_cycles;
    logic              working, busy, done;
    logic [DATA_W-1:0] valE;
    logic [TW:0]       trace_count;
    logic [TW-1:0]     trace_raddr;
    logic [DATA_W-1:0] trace_rdata;

    prog_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    prog_loader #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W), .TRACE_DEPTH(TRACE_DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .prog_len(prog_len),
        .run_cycles(run_cycles), .bus(bus), .working(working), .busy(busy), .done(done),
        .valE(valE), .trace_count(trace_count), .trace_raddr(trace_raddr),
        .trace_rdata(trace_rdata)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state: what the spec says must happen for the stimulus applied.
    logic [DATA_W-1:0] words[$];
    int                exp_n, exp_first;
    int                exp_wen_cyc[$];
    logic [DATA_W-1:0] vrec[int];
    // Observations (cycle n = cycle after the n-th edge following start).
    int                obs_wen_cyc[$], obs_wen_addr[$];
    logic [DATA_W-1:0] obs_wen_dat[$];
    int                obs_work_cyc[$];
    int                obs_done_cyc, obs_ready_cnt, obs_last_ready, obs_tc1;

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] exp_trace(input int k);
        int c;
        c = exp_first + k;
        return (TraceOn && vrec.exists(c)) ? vrec[c] : '0;
    endfunction

    // mode 0: s_valid whenever a word is pending; 1: every other cycle; 2: random.
    task automatic run_seq(input int len, input int rc, input int mode, input bit inject,
                           input bit ramp);
        int  mbeats;
        int  budget;
        bit  v;
        mbeats    = 0;
        exp_n     = (len > MaxLen) ? MaxLen : len;
        exp_first = (exp_n == 0) ? 1 : -1;
        budget    = 4 * exp_n + rc + 20;
        exp_wen_cyc.delete(); vrec.delete();
        obs_wen_cyc.delete(); obs_wen_addr.delete(); obs_wen_dat.delete();
        obs_work_cyc.delete();
        obs_done_cyc = -1; obs_ready_cnt = 0; obs_last_ready = -1; obs_tc1 = -1;
        @(negedge clock);
        start = 1'b1; prog_len = len[ADDR_W:0]; run_cycles = rc[CYC_W-1:0];
        bus.s_valid = 1'b0;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            if (bus.wEn) begin
                obs_wen_cyc.push_back(cyc);
                obs_wen_addr.push_back(int'(bus.addr));
                obs_wen_dat.push_back(bus.wDat);
            end
            if (working) obs_work_cyc.push_back(cyc);
            if (bus.s_ready) begin
                obs_ready_cnt++;
                obs_last_ready = cyc;
            end
            if (cyc == 1) obs_tc1 = int'(trace_count);
            if (done) begin
                obs_done_cyc = cyc;
                break;
            end
            case (mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2) == 1;
                default: v = $urandom_range(0, 3) != 0;
            endcase
            if (mbeats < exp_n && v) begin
                bus.s_valid = 1'b1;
                bus.s_data  = words[mbeats];
                mbeats++;
                exp_wen_cyc.push_back(cyc + 1);
                if (mbeats == exp_n) exp_first = cyc + 2;
            end else begin
                bus.s_valid = 1'b0;
                bus.s_data  = $urandom;
            end
            valE = (ramp && exp_first > 0) ? DATA_W'(100 + cyc - exp_first) : $urandom;
            vrec[cyc] = valE;
            if (inject && (cyc == 2 || (exp_first > 0 && cyc == exp_first + 1))) begin
                start = 1'b1; prog_len = 1; run_cycles = 1;
            end
        end
        bus.s_valid = 1'b0;
        start       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        total++;
        if ({bus.s_ready, bus.wEn, working, busy, done} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {bus.s_ready, bus.wEn, working, busy, done});
        end
        total++;
        if (bus.addr !== '0 || bus.wDat !== '0) begin
            bad++;
            $display("FAIL reset_bus: got addr=%0h wDat=%0h want 0 0", bus.addr, bus.wDat);
        end
        total++;
        if (trace_count !== '0 || trace_rdata !== '0) begin
            bad++;
            $display("FAIL reset_trace: got cnt=%0d rdata=%0h want 0 0", trace_count,
                     trace_rdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        words = '{32'h10f0001c, 32'h10f1001e, 32'h10f20020, 32'h10f30022, 32'h10f40024,
                  32'h10f50026, 32'h20100000, 32'h21320000, 32'h32450000};
        run_seq(9, 9, 0, 1'b0, 1'b0);
        total++;
        if (obs_wen_cyc.size() != 9) begin
            bad++;
            $display("FAIL b2b_wen_count: got %0d want 9", obs_wen_cyc.size());
        end
        for (int k = 0; k < min2(obs_wen_cyc.size(), 9); k++) begin
            total++;
            if (obs_wen_addr[k] != k || obs_wen_dat[k] !== words[k]
                || obs_wen_cyc[k] != exp_wen_cyc[k]) begin
                bad++;
                $display("FAIL b2b_wen[%0d]: got addr=%0d dat=%0h cyc=%0d want %0d %0h %0d",
                         k, obs_wen_addr[k], obs_wen_dat[k], obs_wen_cyc[k], k, words[k],
                         exp_wen_cyc[k]);
            end
        end
        total++;
        if (obs_work_cyc.size() != 9 || obs_work_cyc[0] != exp_first
            || obs_work_cyc[obs_work_cyc.size()-1] != exp_first + 8) begin
            bad++;
            $display("FAIL b2b_working: got n=%0d first=%0d want n=9 first=%0d",
                     obs_work_cyc.size(), (obs_work_cyc.size() > 0) ? obs_work_cyc[0] : -1,
                     exp_first);
        end
        total++;
        if (obs_done_cyc != exp_first + 9) begin
            bad++;
            $display("FAIL b2b_done: got cyc=%0d want %0d", obs_done_cyc, exp_first + 9);
        end
        total++;
        if (obs_ready_cnt != 9 || obs_last_ready != exp_wen_cyc[8] - 1) begin
            bad++;
            $display("FAIL b2b_ready: got n=%0d last=%0d want 9 %0d", obs_ready_cnt,
                     obs_last_ready, exp_wen_cyc[8] - 1);
        end
    endtask

    task automatic test_stall();
        run_seq(9, 9, 1, 1'b0, 1'b0);
        total++;
        if (obs_wen_cyc.size() != 9) begin
            bad++;
            $display("FAIL stall_wen_count: got %0d want 9", obs_wen_cyc.size());
        end
        for (int k = 0; k < min2(obs_wen_cyc.size(), 9); k++) begin
            total++;
            if (obs_wen_addr[k] != k || obs_wen_dat[k] !== words[k]
                || obs_wen_cyc[k] != exp_wen_cyc[k]) begin
                bad++;
                $display("FAIL stall_wen[%0d]: got addr=%0d dat=%0h cyc=%0d want %0d %0h %0d",
                         k, obs_wen_addr[k], obs_wen_dat[k], obs_wen_cyc[k], k, words[k],
                         exp_wen_cyc[k]);
            end
        end
        total++;
        if (obs_work_cyc.size() != 9 || obs_work_cyc[0] != exp_first) begin
            bad++;
            $display("FAIL stall_working: got n=%0d first=%0d want n=9 first=%0d",
                     obs_work_cyc.size(), (obs_work_cyc.size() > 0) ? obs_work_cyc[0] : -1,
                     exp_first);
        end
    endtask

    task automatic test_trace();
        logic [TW:0] exp_tc;
        run_seq(9, 9, 0, 1'b0, 1'b1);
        exp_tc = TraceOn ? (TW+1)'(TRACE_DEPTH) : '0;
        total++;
        if (trace_count !== exp_tc) begin
            bad++;
            $display("FAIL trace_count: got %0d want %0d", trace_count, exp_tc);
        end
        for (int k = 0; k < int'(TRACE_DEPTH); k++) begin
            @(negedge clock);
            trace_raddr = TW'(k);
            @(negedge clock);
            total++;
            if (trace_rdata !== exp_trace(k)) begin
                bad++;
                $display("FAIL trace_rd[%0d]: got %0d want %0d", k, trace_rdata, exp_trace(k));
            end
        end
    endtask

    task automatic test_zero_len();
        run_seq(0, 3, 0, 1'b0, 1'b0);
        total++;
        if (obs_wen_cyc.size() != 0 || obs_work_cyc.size() != 3 || obs_work_cyc[0] != 1
            || obs_done_cyc != 4) begin
            bad++;
            $display("FAIL zero_len_run3: got wen=%0d work=%0d done=%0d want 0 3 4",
                     obs_wen_cyc.size(), obs_work_cyc.size(), obs_done_cyc);
        end
        run_seq(0, 0, 0, 1'b0, 1'b0);
        total++;
        if (obs_work_cyc.size() != 0 || obs_done_cyc < 0) begin
            bad++;
            $display("FAIL zero_len_run0: got work=%0d done=%0d want 0 seen",
                     obs_work_cyc.size(), obs_done_cyc);
        end
        run_seq(5, 0, 0, 1'b0, 1'b0);
        total++;
        if (obs_wen_cyc.size() != 5 || obs_work_cyc.size() != 0 || obs_done_cyc < 0) begin
            bad++;
            $display("FAIL load5_run0: got wen=%0d work=%0d done=%0d want 5 0 seen",
                     obs_wen_cyc.size(), obs_work_cyc.size(), obs_done_cyc);
        end
    endtask

    task automatic test_reset_mid_load();
        words.delete();
        for (int k = 0; k < 9; k++) words.push_back($urandom);
        @(negedge clock);
        start = 1'b1; prog_len = 9; run_cycles = 4;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            start = 1'b0; bus.s_valid = 1'b1; bus.s_data = words[c-1];
        end
        @(negedge clock);
        bus.s_valid = 1'b0;
        total++;
        if (busy !== 1'b1 || bus.s_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_loading: got busy=%b ready=%b want 1 1", busy, bus.s_ready);
        end
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({bus.s_ready, bus.wEn, working, busy, done} !== 5'b0 || bus.addr !== '0
            || bus.wDat !== '0 || trace_count !== '0 || trace_rdata !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got flags=%b addr=%0h wDat=%0h cnt=%0d rd=%0h want 0",
                     {bus.s_ready, bus.wEn, working, busy, done}, bus.addr, bus.wDat,
                     trace_count, trace_rdata);
        end
        reset = 1'b0;
        words.delete();
        for (int k = 0; k < 6; k++) words.push_back($urandom);
        run_seq(6, 2, 0, 1'b0, 1'b0);
        total++;
        if (obs_wen_cyc.size() != 6) begin
            bad++;
            $display("FAIL rst_restart_count: got %0d want 6", obs_wen_cyc.size());
        end
        for (int k = 0; k < min2(obs_wen_cyc.size(), 6); k++) begin
            total++;
            if (obs_wen_addr[k] != k || obs_wen_dat[k] !== words[k]) begin
                bad++;
                $display("FAIL rst_restart[%0d]: got addr=%0d dat=%0h want %0d %0h", k,
                         obs_wen_addr[k], obs_wen_dat[k], k, words[k]);
            end
        end
    endtask

    task automatic test_start_ignored();
        logic [TW:0] exp_tc;
        words.delete();
        for (int k = 0; k < 6; k++) words.push_back($urandom);
        run_seq(6, 5, 0, 1'b1, 1'b0);
        total++;
        if (obs_wen_cyc.size() != 6 || obs_work_cyc.size() != 5 || obs_work_cyc[0] != exp_first
            || obs_done_cyc != exp_first + 5) begin
            bad++;
            $display("FAIL start_ignored: got wen=%0d work=%0d done=%0d want 6 5 %0d",
                     obs_wen_cyc.size(), obs_work_cyc.size(), obs_done_cyc, exp_first + 5);
        end
        exp_tc = TraceOn ? (TW+1)'(TRACE_DEPTH) : '0;
        total++;
        if (trace_count !== exp_tc) begin
            bad++;
            $display("FAIL start_ign_tcount: got %0d want %0d", trace_count, exp_tc);
        end
        run_seq(3, 2, 0, 1'b0, 1'b0);
        total++;
        if (obs_tc1 != 0 || obs_wen_cyc.size() != 3 || obs_wen_addr[0] != 0) begin
            bad++;
            $display("FAIL done_restart: got tcnt=%0d wen=%0d want 0 3", obs_tc1,
                     obs_wen_cyc.size());
        end
    endtask

    task automatic test_clamp();
        words.delete();
        for (int k = 0; k < 20; k++) words.push_back($urandom);
        run_seq(20, 2, 0, 1'b0, 1'b0);
        total++;
        if (obs_wen_cyc.size() != MaxLen || obs_work_cyc.size() != 2) begin
            bad++;
            $display("FAIL clamp_count: got wen=%0d work=%0d want %0d 2", obs_wen_cyc.size(),
                     obs_work_cyc.size(), MaxLen);
        end
        for (int k = 0; k < min2(obs_wen_cyc.size(), MaxLen); k++) begin
            total++;
            if (obs_wen_addr[k] != k || obs_wen_dat[k] !== words[k]) begin
                bad++;
                $display("FAIL clamp_wen[%0d]: got addr=%0d dat=%0h want %0d %0h", k,
                         obs_wen_addr[k], obs_wen_dat[k], k, words[k]);
            end
        end
    endtask

    task automatic test_random();
        int          len, rc, nw, exp_last_ready;
        logic [TW:0] exp_tc;
        for (int it = 0; it < 8; it++) begin
            len = $urandom_range(0, 20);
            rc  = $urandom_range(0, 12);
            words.delete();
            for (int k = 0; k < 20; k++) words.push_back($urandom);
            run_seq(len, rc, 2, 1'b0, 1'b0);
            nw = obs_wen_cyc.size();
            total++;
            if (nw != exp_n) begin
                bad++;
                $display("FAIL rnd%0d_wen_count: got %0d want %0d", it, nw, exp_n);
            end
            for (int k = 0; k < min2(nw, exp_n); k++) begin
                total++;
                if (obs_wen_addr[k] != k || obs_wen_dat[k] !== words[k]
                    || obs_wen_cyc[k] != exp_wen_cyc[k]) begin
                    bad++;
                    $display("FAIL rnd%0d_wen[%0d]: got addr=%0d dat=%0h cyc=%0d want %0d %0h %0d",
                             it, k, obs_wen_addr[k], obs_wen_dat[k], obs_wen_cyc[k], k,
                             words[k], exp_wen_cyc[k]);
                end
            end
            total++;
            if (obs_work_cyc.size() != rc
                || (rc > 0 && (obs_work_cyc[0] != exp_first || obs_done_cyc != exp_first + rc))
                || obs_done_cyc < 0) begin
                bad++;
                $display("FAIL rnd%0d_run: got work=%0d done=%0d want %0d first=%0d", it,
                         obs_work_cyc.size(), obs_done_cyc, rc, exp_first);
            end
            exp_last_ready = (exp_n > 0) ? exp_wen_cyc[exp_n-1] - 1 : -1;
            total++;
            if (obs_last_ready != exp_last_ready
                || obs_ready_cnt != ((exp_n > 0) ? exp_last_ready : 0)) begin
                bad++;
                $display("FAIL rnd%0d_ready: got n=%0d last=%0d want last=%0d", it,
                         obs_ready_cnt, obs_last_ready, exp_last_ready);
            end
            exp_tc = TraceOn ? (TW+1)'(min2(rc, int'(TRACE_DEPTH))) : '0;
            total++;
            if (trace_count !== exp_tc) begin
                bad++;
                $display("FAIL rnd%0d_tcount: got %0d want %0d", it, trace_count, exp_tc);
            end
            if (rc > 0) begin
                @(negedge clock);
                trace_raddr = '0;
                @(negedge clock);
                total++;
                if (trace_rdata !== exp_trace(0)) begin
                    bad++;
                    $display("FAIL rnd%0d_trace0: got %0h want %0h", it, trace_rdata,
                             exp_trace(0));
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; prog_len = '0; run_cycles = '0;
        valE = '0; trace_raddr = '0; bus.s_valid = 1'b0; bus.s_data = '0;
        test_reset();
        test_back_to_back();
        test_stall();
        test_trace();
        test_zero_len();
        test_reset_mid_load();
        test_start_ignored();
        test_clamp();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
